// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the hazard/stall controller.
// Memory-wait state encoding, the x0 register index and default timeout.
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } mw_state_e;

  localparam logic [4:0] REG_ZERO     = 5'd0;
  localparam int         MAX_WAIT_DEF = 16;

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Data-memory handshake seen by the hazard/stall controller.
// slave: the controller; master: the MEM stage / memory side.
interface hazard_stall_ctrl_if;

  logic MEM_MemRead;
  logic MEM_MemWrite;
  logic mem_ready_i;
  logic mem_req_o;

  modport master (
    output MEM_MemRead,
    output MEM_MemWrite,
    output mem_ready_i,
    input  mem_req_o
  );

  modport slave (
    input  MEM_MemRead,
    input  MEM_MemWrite,
    input  mem_ready_i,
    output mem_req_o
  );

endinterface

// File: rtl/hazard_stall_ctrl_mem_wait_fsm.sv
// Memory-wait FSM: freezes the pipe while a MEM access is unacked.
// Times out into a terminal ERR state after MAX_WAIT wait cycles.
module mem_wait_fsm
  import hazard_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int CNT_W    = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic access_i,
  input  logic mem_ready_i,
  output logic mem_req_o,
  output logic pipe_stall_o,
  output logic mem_err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mw_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;

  // State and wait counter registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sticky error flag, set the cycle after ERR is entered
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) err_q <= 1'b0;
    else        err_q <= err_q | (state_q == ERR);
  end

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (access_i && !mem_ready_i) begin
          state_d = WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT: begin
        if (mem_ready_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Request and freeze outputs; stall drops the cycle ready rises
  always_comb begin
    mem_req_o    = 1'b0;
    pipe_stall_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        mem_req_o    = access_i;
        pipe_stall_o = access_i & ~mem_ready_i;
      end
      WAIT: begin
        mem_req_o    = access_i;
        pipe_stall_o = ~mem_ready_i;
      end
      ERR: begin
        pipe_stall_o = 1'b1;
      end
      default: begin
        mem_req_o    = 1'b0;
        pipe_stall_o = 1'b0;
      end
    endcase
  end

  assign mem_err_o = err_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: load-use bubbles, branch flush gating, mem freeze.
// Optional HAZARD_STATS_EN adds saturating stall/bubble counters.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int CNT_W    = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  hazard_stall_ctrl_if.slave   mif,
  input  logic [4:0]           ID_rs1,
  input  logic [4:0]           ID_rs2,
  input  logic                 ID_uses_rs2,
  input  logic [4:0]           EX_Rd,
  input  logic                 EX_MemRead,
  input  logic                 Branch_taken,
  output logic                 PCWrite_o,
  output logic                 IFID_Write_o,
  output logic                 IDEX_Bubble_o,
  output logic                 IFID_Flush_o,
  output logic                 pipe_stall_o,
  output logic                 mem_err_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]          stall_cycles_o,
  output logic [31:0]          bubble_cnt_o
`endif
);

  logic access;
  logic load_use;
  logic req;

  assign access = mif.MEM_MemRead | mif.MEM_MemWrite;

  assign load_use = EX_MemRead & (EX_Rd != REG_ZERO) &
                    ((EX_Rd == ID_rs1) |
                     (ID_uses_rs2 & (EX_Rd == ID_rs2)));

  mem_wait_fsm #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) u_fsm (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .access_i     (access),
    .mem_ready_i  (mif.mem_ready_i),
    .mem_req_o    (req),
    .pipe_stall_o (pipe_stall_o),
    .mem_err_o    (mem_err_o)
  );

  assign mif.mem_req_o = req;

  // Freeze beats bubble beats normal flow; flush only in normal flow
  always_comb begin
    PCWrite_o     = 1'b1;
    IFID_Write_o  = 1'b1;
    IDEX_Bubble_o = 1'b0;
    IFID_Flush_o  = 1'b0;
    unique case (1'b1)
      pipe_stall_o: begin
        PCWrite_o    = 1'b0;
        IFID_Write_o = 1'b0;
      end
      (~pipe_stall_o & load_use): begin
        PCWrite_o     = 1'b0;
        IFID_Write_o  = 1'b0;
        IDEX_Bubble_o = 1'b1;
      end
      default: begin
        IFID_Flush_o = Branch_taken;
      end
    endcase
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_q, bubble_q;

  // Saturating stall and bubble cycle counters
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (pipe_stall_o && stall_q != 32'hFFFF_FFFF)
        stall_q <= stall_q + 32'd1;
      if (IDEX_Bubble_o && bubble_q != 32'hFFFF_FFFF)
        bubble_q <= bubble_q + 32'd1;
    end
  end

  assign stall_cycles_o = stall_q;
  assign bubble_cnt_o   = bubble_q;
`endif

endmodule
